// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings, constants and helpers for the pong match controller
//
// Purpose: single home for the match FSM encoding, ball center coordinates and
// the default match parameters so the controller, its tick counter and the
// renderer all agree on them.
// Ports: none (package).

package pong_pkg;

    // One-hot match states; GAME_OVER is deliberately the all-zero code so the
    // renderer can treat "no bit set" as the end-of-match palette.
    typedef enum logic [2:0] {
        ST_GAME_OVER = 3'b000,
        ST_IDLE      = 3'b001,
        ST_SERVE     = 3'b010,
        ST_PLAY      = 3'b100
    } state_t;

    localparam int BALL_CENTER_X   = 463;
    localparam int BALL_CENTER_Y   = 275;

    localparam int WIN_SCORE_DEF   = 7;
    localparam int SERVE_TICKS_DEF = 100;

    localparam int CNT_W           = 10;
    localparam int SCORE_W         = 4;

    // Saturating score increment: never passes the winning score, so a 4-bit
    // score can never wrap regardless of how many misses arrive.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                   input logic [SCORE_W-1:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/pong_tick_counter.sv
// rtl/pong_tick_counter.sv - 10-bit frame tick counter with clear, enable and terminal-count flag
//
// Purpose: counts frame ticks while the ball is held for a serve.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear (wins over en)
//   en          count enable, one per frame tick
//   tc          high when the current enabled tick is the TERMINAL-th one

module pong_tick_counter
    import pong_pkg::*;
#(
    parameter int TERMINAL = SERVE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] count;

    // The flag looks one tick ahead: it fires on the tick that would make the
    // count reach TERMINAL, so the owner can act on that very edge and the
    // stored count never has to hold TERMINAL itself.
    assign tc = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: serve timing, scoring and game-over detection
//
// Purpose: runs a pong match as IDLE -> SERVE -> PLAY -> (SERVE | GAME_OVER).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  one-cycle frame strobe, the time base for serve delay
//   start                 level, begins a match from IDLE or GAME_OVER
//   p2_mode               0 = single player vs right wall, 1 = two players
//   miss_left/right       one-cycle pulses, ball passed that paddle
//   ball_hold             ball parked at center
//   serve, serve_dir      release pulse and direction (1 = right)
//   score_p1, score_p2    match score
//   mode_p2               p2_mode latched at match start
//   game_over, winner     end of match and winning side (1 = P2)
//   state_o               one-hot state code for the renderer

module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int SERVE_TICKS = SERVE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       p2_mode,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_hold,
    output logic       serve,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       mode_p2,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_o
);

    localparam logic [SCORE_W-1:0] WIN4 = SCORE_W'(WIN_SCORE);

    state_t            state, state_n;
    logic [3:0]        p1_q, p1_n;
    logic [3:0]        p2_q, p2_n;
    logic              dir_q, dir_n;
    logic              mode_q, mode_n;
    logic              serve_q, serve_n;
    logic              winner_q, winner_n;
    logic              cnt_clr, cnt_en, cnt_tc;

    pong_tick_counter #(
        .TERMINAL (SERVE_TICKS)
    ) u_tick_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            dir_q    <= 1'b0;
            mode_q   <= 1'b0;
            serve_q  <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state    <= state_n;
            p1_q     <= p1_n;
            p2_q     <= p2_n;
            dir_q    <= dir_n;
            mode_q   <= mode_n;
            serve_q  <= serve_n;
            winner_q <= winner_n;
        end
    end

    always_comb begin
        state_n  = state;
        p1_n     = p1_q;
        p2_n     = p2_q;
        dir_n    = dir_q;
        mode_n   = mode_q;
        serve_n  = 1'b0;
        winner_n = winner_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    p1_n    = '0;
                    p2_n    = '0;
                    mode_n  = p2_mode;
                    dir_n   = 1'b0;
                    cnt_clr = 1'b1;
                    state_n = ST_SERVE;
                end
            end

            ST_SERVE: begin
                cnt_en = tick;
                if (cnt_tc) begin
                    serve_n = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = ST_PLAY;
                end
            end

            ST_PLAY: begin
                // miss_left has priority; in single-player mode the right
                // side is a wall, so miss_right is never a point.
                if (miss_left) begin
                    p2_n    = sat_inc(p2_q, WIN4);
                    dir_n   = 1'b0;
                    cnt_clr = 1'b1;
                    if (p2_n == WIN4) begin
                        winner_n = 1'b1;
                        state_n  = ST_GAME_OVER;
                    end else begin
                        state_n  = ST_SERVE;
                    end
                end else if (miss_right && mode_q) begin
                    p1_n    = sat_inc(p1_q, WIN4);
                    dir_n   = 1'b1;
                    cnt_clr = 1'b1;
                    if (p1_n == WIN4) begin
                        winner_n = 1'b0;
                        state_n  = ST_GAME_OVER;
                    end else begin
                        state_n  = ST_SERVE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign ball_hold = (state != ST_PLAY);
    assign serve     = serve_q;
    assign serve_dir = dir_q;
    assign score_p1  = p1_q;
    assign score_p2  = p2_q;
    assign mode_p2   = mode_q;
    assign game_over = (state == ST_GAME_OVER);
    assign winner    = winner_q;
    assign state_o   = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - self-checking bench for pong_match_ctrl with a match-level reference model

module tb_pong_match_ctrl;

    localparam int W  = 7;
    localparam int ST = 100;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       p2_mode = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_hold;
    logic       serve;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       mode_p2;
    logic       game_over;
    logic       winner;
    logic [2:0] state_o;

    pong_match_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start      (start),
        .p2_mode    (p2_mode),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_hold  (ball_hold),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .mode_p2    (mode_p2),
        .game_over  (game_over),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase;
    int m_p1, m_p2, m_ticks;
    bit m_dir, m_mode, m_serve, m_win;
    int n_serves;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] phase_code(input int ph);
        case (ph)
            PH_IDLE:  return 3'b001;
            PH_SERVE: return 3'b010;
            PH_PLAY:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_p1 = 0; m_p2 = 0; m_ticks = 0;
        m_dir = 0; m_mode = 0; m_serve = 0; m_win = 0;
    endtask

    task automatic model_clock(input bit st, input bit tk, input bit ml, input bit mr, input bit p2m);
        m_serve = 0;
        case (m_phase)
            PH_IDLE, PH_OVER: begin
                if (st) begin
                    m_p1 = 0; m_p2 = 0; m_mode = p2m; m_dir = 0; m_ticks = 0;
                    m_phase = PH_SERVE;
                end
            end
            PH_SERVE: begin
                if (tk) begin
                    m_ticks++;
                    if (m_ticks == ST) begin
                        m_serve = 1; m_ticks = 0; m_phase = PH_PLAY; n_serves++;
                    end
                end
            end
            default: begin
                if (ml) begin
                    if (m_p2 < W) m_p2++;
                    m_dir = 0;
                    if (m_p2 == W) begin m_win = 1; m_phase = PH_OVER; end
                    else m_phase = PH_SERVE;
                end else if (mr && m_mode) begin
                    if (m_p1 < W) m_p1++;
                    m_dir = 1;
                    if (m_p1 == W) begin m_win = 0; m_phase = PH_OVER; end
                    else m_phase = PH_SERVE;
                end
            end
        endcase
    endtask

    function automatic logic [16:0] exp_vec();
        logic over;
        over = (m_phase == PH_OVER);
        return {phase_code(m_phase), m_serve, (m_phase != PH_PLAY), m_dir,
                4'(m_p1), 4'(m_p2), m_mode, over, over & m_win};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {state_o, serve, ball_hold, serve_dir, score_p1, score_p2,
                mode_p2, game_over, winner & game_over};
    endfunction

    task automatic step(input bit st, input bit tk, input bit ml, input bit mr);
        start = st; tick = tk; miss_left = ml; miss_right = mr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_clock(st, tk, ml, mr, p2_mode);
        #1;
        check("outputs", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    // Holds the ball for a full serve delay with a tick every cycle.
    task automatic run_serve(input string tag);
        for (int i = 0; i < ST; i++) step(0, 1, 0, 0);
        check(tag, {31'd0, serve}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'h1);
        check({tag, "_scores"}, 32'({score_p1, score_p2}), 32'h0);
        check({tag, "_flags"}, 32'({serve, serve_dir, mode_p2, winner, game_over, ball_hold}), 32'h1);
    endtask

    initial begin
        model_reset();
        n_serves = 0;

        // Reset state.
        repeat (3) step(0, 0, 0, 0);
        check_reset_values("reset");
        rst_n = 1'b1;

        // First serve: one tick per 10 clocks; serve one clock after tick 100.
        p2_mode = 1'b1;
        step(1, 0, 0, 0);
        check("start_to_serve", 32'(state_o), 32'h2);
        for (int t = 1; t <= ST; t++) begin
            repeat (9) step(0, 0, 0, 0);
            step(0, 1, 0, 0);
        end
        check("first_serve", 32'({serve, ball_hold}), 32'h2);
        step(1, 0, 0, 0);
        check("serve_one_cycle", 32'({serve, state_o}), 32'h4);

        // miss_right in two-player play.
        step(0, 0, 0, 1);
        check("miss_right", 32'({score_p1, serve_dir, state_o}), 32'h1A);
        run_serve("serve_after_point");

        // Simultaneous misses: only the left one scores.
        step(0, 0, 1, 1);
        check("both_miss", 32'({score_p1, score_p2}), 32'h11);
        run_serve("serve_after_both");

        // Left side keeps missing until P2 wins.
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 1, 0);
            if (k < 5) run_serve("serve_mid_match");
        end
        check("win_p2", 32'({score_p2, game_over, winner}), 32'h1F);
        step(0, 0, 1, 0);
        step(0, 1, 0, 1);
        step(0, 0, 1, 1);
        check("over_holds", 32'({score_p1, score_p2, game_over}), 32'h2F);
        step(1, 0, 0, 0);
        check("restart", 32'({score_p1, score_p2, state_o}), 32'h2);

        // Reset at tick 50 of a serve: no serve, everything back to reset values.
        for (int i = 0; i < 50; i++) step(0, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        step(0, 1, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * ST; i++) step(0, 1, 0, 0);
        check_reset_values("after_reset");

        // Single player: right misses are the wall, not points; p2_mode is latched at start.
        p2_mode = 1'b0;
        step(1, 0, 0, 0);
        p2_mode = 1'b1;
        run_serve("sp_serve");
        repeat (3) step(0, 0, 0, 1);
        check("sp_right_ignored", 32'({score_p1, mode_p2, state_o}), 32'h4);
        step(0, 0, 1, 0);
        check("sp_left_scores", 32'(score_p2), 32'h1);

        // Randomized play against the model.
        for (int c = 0; c < 30000; c++) begin
            p2_mode = 1'($urandom % 2);
            if ($urandom % 3000 == 0) rst_n = 1'b0;
            step(($urandom % 40) == 0, 1'($urandom % 2),
                 ($urandom % 12) == 0, ($urandom % 12) == 0);
            rst_n = 1'b1;
        end
        check("random_serves_seen", 32'(n_serves > 20), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
